// File: rtl/issue_pair_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : issue_pair_ctrl
// Brief    : Dual-issue pair buffer and sequencer with fetch-PC ownership and
//            saturating stall/split/flush performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module issue_pair_ctrl #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            fetch_valid,
    input  logic [PC_W-1:0] fetch_pc,
    input  logic [0:31]     fetch_instr1,
    input  logic [0:31]     fetch_instr2,
    input  logic            fetch_type1,
    input  logic            fetch_type2,
    output logic            fetch_ready,
    input  logic            stall,
    input  logic            dependent_stall,
    input  logic            flush,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] pc_next,
    output logic [0:31]     buf_instr1,
    output logic [0:31]     buf_instr2,
    output logic            buf_type1,
    output logic            buf_type2,
    output logic            issue_even_valid,
    output logic [0:31]     issue_even_instr,
    output logic [PC_W-1:0] issue_even_pc,
    output logic            issue_odd_valid,
    output logic [0:31]     issue_odd_instr,
    output logic [PC_W-1:0] issue_odd_pc,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] split_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam logic [1:0]  c_S_EMPTY  = 2'd0;
    localparam logic [1:0]  c_S_PAIR   = 2'd1;
    localparam logic [1:0]  c_S_SECOND = 2'd2;
    localparam logic [0:31] c_NOP      = 32'h4020_0000;
    localparam logic [0:31] c_LNOP     = 32'h0020_0000;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [0:31]      r_instr1;
    logic [0:31]      r_instr2;
    logic             r_type1;
    logic             r_type2;
    logic [PC_W-1:0]  r_buf_pc;
    logic [PC_W-1:0]  r_pc_next;
    logic [CNT_W-1:0] r_stall_cycles;
    logic [CNT_W-1:0] r_split_count;
    logic [CNT_W-1:0] r_flush_count;

    logic w_conflict;
    logic w_drain;
    logic w_iss1;
    logic w_iss2;
    logic w_stall_inc;
    logic w_split_inc;
    logic w_flush_inc;
    logic w_accept;

    // Same-type pairs are split even if the hazard unit does not ask for it.
    assign w_conflict = dependent_stall | (r_type1 == r_type2);

    always_comb begin
        w_state_nxt = r_state;
        w_drain     = 1'b0;
        w_iss1      = 1'b0;
        w_iss2      = 1'b0;
        w_stall_inc = 1'b0;
        w_split_inc = 1'b0;
        w_flush_inc = 1'b0;
        case (r_state)
            c_S_EMPTY: begin
                if (fetch_valid && !flush) w_state_nxt = c_S_PAIR;
            end
            c_S_PAIR: begin
                if (flush) begin
                    w_state_nxt = c_S_EMPTY;
                    w_flush_inc = 1'b1;
                end else if (stall) begin
                    w_stall_inc = 1'b1;
                end else if (w_conflict) begin
                    w_iss1      = 1'b1;
                    w_split_inc = 1'b1;
                    w_state_nxt = c_S_SECOND;
                end else begin
                    w_iss1      = 1'b1;
                    w_iss2      = 1'b1;
                    w_drain     = 1'b1;
                    w_state_nxt = fetch_valid ? c_S_PAIR : c_S_EMPTY;
                end
            end
            c_S_SECOND: begin
                if (flush) begin
                    w_state_nxt = c_S_EMPTY;
                    w_flush_inc = 1'b1;
                end else if (stall) begin
                    w_stall_inc = 1'b1;
                end else begin
                    w_iss2      = 1'b1;
                    w_drain     = 1'b1;
                    w_state_nxt = fetch_valid ? c_S_PAIR : c_S_EMPTY;
                end
            end
            default: w_state_nxt = c_S_EMPTY;
        endcase
    end

    // Slot steering: when both issue, their types differ, so slots never collide.
    always_comb begin
        issue_even_valid = 1'b0;
        issue_even_instr = c_NOP;
        issue_even_pc    = '0;
        issue_odd_valid  = 1'b0;
        issue_odd_instr  = c_LNOP;
        issue_odd_pc     = '0;
        if (w_iss1) begin
            if (r_type1) begin
                issue_odd_valid  = 1'b1;
                issue_odd_instr  = r_instr1;
                issue_odd_pc     = r_buf_pc;
            end else begin
                issue_even_valid = 1'b1;
                issue_even_instr = r_instr1;
                issue_even_pc    = r_buf_pc;
            end
        end
        if (w_iss2) begin
            if (r_type2) begin
                issue_odd_valid  = 1'b1;
                issue_odd_instr  = r_instr2;
                issue_odd_pc     = r_buf_pc + PC_W'(4);
            end else begin
                issue_even_valid = 1'b1;
                issue_even_instr = r_instr2;
                issue_even_pc    = r_buf_pc + PC_W'(4);
            end
        end
    end

    assign fetch_ready = ((r_state == c_S_EMPTY) || w_drain) && !flush;
    assign w_accept    = fetch_valid && fetch_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= c_S_EMPTY;
            r_instr1       <= c_NOP;
            r_instr2       <= c_LNOP;
            r_type1        <= 1'b0;
            r_type2        <= 1'b1;
            r_buf_pc       <= '0;
            r_pc_next      <= '0;
            r_stall_cycles <= '0;
            r_split_count  <= '0;
            r_flush_count  <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (flush) begin
                r_pc_next <= branch_target;
            end else if (w_accept) begin
                r_pc_next <= r_pc_next + PC_W'(8);
            end
            if (w_accept) begin
                r_instr1 <= fetch_instr1;
                r_instr2 <= fetch_instr2;
                r_type1  <= fetch_type1;
                r_type2  <= fetch_type2;
                r_buf_pc <= fetch_pc;
            end
            if (w_stall_inc && (r_stall_cycles != '1)) r_stall_cycles <= r_stall_cycles + CNT_W'(1);
            if (w_split_inc && (r_split_count != '1))  r_split_count  <= r_split_count + CNT_W'(1);
            if (w_flush_inc && (r_flush_count != '1))  r_flush_count  <= r_flush_count + CNT_W'(1);
        end
    end

    assign pc_next      = r_pc_next;
    assign buf_instr1   = r_instr1;
    assign buf_instr2   = r_instr2;
    assign buf_type1    = r_type1;
    assign buf_type2    = r_type2;
    assign stall_cycles = r_stall_cycles;
    assign split_count  = r_split_count;
    assign flush_count  = r_flush_count;

endmodule
`default_nettype wire

// File: tb/tb_issue_pair_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_pair_ctrl
// Brief    : Self-checking bench for issue_pair_ctrl: vector table, directed
//            stall/flush/saturation sequences and a queue-based random model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_issue_pair_ctrl;

    localparam logic [31:0] c_NOP  = 32'h4020_0000;
    localparam logic [31:0] c_LNOP = 32'h0020_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [0:31] fetch_instr1, fetch_instr2;
    logic        fetch_type1, fetch_type2;
    logic        fetch_ready;
    logic        stall, dependent_stall, flush;
    logic [31:0] branch_target;
    logic [31:0] pc_next;
    logic [0:31] buf_instr1, buf_instr2;
    logic        buf_type1, buf_type2;
    logic        issue_even_valid, issue_odd_valid;
    logic [0:31] issue_even_instr, issue_odd_instr;
    logic [31:0] issue_even_pc, issue_odd_pc;
    logic [15:0] stall_cycles, split_count, flush_count;

    issue_pair_ctrl #(.PC_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset),
        .fetch_valid(fetch_valid), .fetch_pc(fetch_pc),
        .fetch_instr1(fetch_instr1), .fetch_instr2(fetch_instr2),
        .fetch_type1(fetch_type1), .fetch_type2(fetch_type2),
        .fetch_ready(fetch_ready),
        .stall(stall), .dependent_stall(dependent_stall), .flush(flush),
        .branch_target(branch_target), .pc_next(pc_next),
        .buf_instr1(buf_instr1), .buf_instr2(buf_instr2),
        .buf_type1(buf_type1), .buf_type2(buf_type2),
        .issue_even_valid(issue_even_valid), .issue_even_instr(issue_even_instr),
        .issue_even_pc(issue_even_pc),
        .issue_odd_valid(issue_odd_valid), .issue_odd_instr(issue_odd_instr),
        .issue_odd_pc(issue_odd_pc),
        .stall_cycles(stall_cycles), .split_count(split_count), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic        fv;
        logic [31:0] pc, i1, i2;
        logic        t1, t2, dep;
        logic        ev;
        logic [31:0] ei, epc;
        logic        ov;
        logic [31:0] oi, opc;
        logic        rdy;
        logic [31:0] pcn;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic        typ;
        logic [31:0] pc;
    } ent_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] i1,
                         input logic [31:0] i2, input logic t1, input logic t2,
                         input logic st, input logic dp, input logic fl, input logic [31:0] tgt);
        fetch_valid = fv; fetch_pc = pc; fetch_instr1 = i1; fetch_instr2 = i2;
        fetch_type1 = t1; fetch_type2 = t2; stall = st; dependent_stall = dp;
        flush = fl; branch_target = tgt;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_issue(input string tag, input logic ev, input logic [31:0] ei,
                             input logic [31:0] epc, input logic ov, input logic [31:0] oi,
                             input logic [31:0] opc, input logic rdy);
        #1;
        chk({tag, " even_valid"}, {31'b0, issue_even_valid}, {31'b0, ev});
        chk({tag, " even_instr"}, issue_even_instr, ei);
        chk({tag, " even_pc"},    issue_even_pc, epc);
        chk({tag, " odd_valid"},  {31'b0, issue_odd_valid}, {31'b0, ov});
        chk({tag, " odd_instr"},  issue_odd_instr, oi);
        chk({tag, " odd_pc"},     issue_odd_pc, opc);
        chk({tag, " fetch_ready"}, {31'b0, fetch_ready}, {31'b0, rdy});
    endtask

    task automatic chk_none(input string tag, input logic rdy);
        chk_issue(tag, 1'b0, c_NOP, 32'h0, 1'b0, c_LNOP, 32'h0, rdy);
    endtask

    vec_t vecs[7];
    ent_t mq[$];
    ent_t iss[$];

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1'b1, 32'h0,  32'hA000_0001, 32'hB000_0002, 1'b0, 1'b1, 1'b0,
                    1'b0, c_NOP, 32'h0, 1'b0, c_LNOP, 32'h0, 1'b1, 32'h8};
        vecs[1] = '{1'b1, 32'h8,  32'hC000_0003, 32'hD000_0004, 1'b1, 1'b0, 1'b0,
                    1'b1, 32'hA000_0001, 32'h0, 1'b1, 32'hB000_0002, 32'h4, 1'b1, 32'h10};
        vecs[2] = '{1'b0, 32'h0,  32'h0, 32'h0, 1'b0, 1'b0, 1'b1,
                    1'b0, c_NOP, 32'h0, 1'b1, 32'hC000_0003, 32'h8, 1'b0, 32'h10};
        vecs[3] = '{1'b0, 32'h0,  32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                    1'b1, 32'hD000_0004, 32'hC, 1'b0, c_LNOP, 32'h0, 1'b1, 32'h10};
        vecs[4] = '{1'b1, 32'h10, 32'hE000_0005, 32'hF000_0006, 1'b0, 1'b0, 1'b0,
                    1'b0, c_NOP, 32'h0, 1'b0, c_LNOP, 32'h0, 1'b1, 32'h18};
        vecs[5] = '{1'b0, 32'h0,  32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                    1'b1, 32'hE000_0005, 32'h10, 1'b0, c_LNOP, 32'h0, 1'b0, 32'h18};
        vecs[6] = '{1'b0, 32'h0,  32'h0, 32'h0, 1'b0, 1'b0, 1'b0,
                    1'b1, 32'hF000_0006, 32'h14, 1'b0, c_LNOP, 32'h0, 1'b1, 32'h18};

        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Reset state
        chk_none("reset", 1'b1);
        chk("reset pc_next", pc_next, 32'h0);
        chk("reset stall_cycles", {16'h0, stall_cycles}, 32'h0);
        chk("reset split_count", {16'h0, split_count}, 32'h0);
        chk("reset flush_count", {16'h0, flush_count}, 32'h0);
        chk("reset buf_instr1", buf_instr1, c_NOP);
        chk("reset buf_instr2", buf_instr2, c_LNOP);
        chk("reset buf_types", {30'b0, buf_type1, buf_type2}, 32'h1);

        // Vector table: co-issue, dependent split, same-type split
        for (int i = 0; i < 7; i++) begin
            drive(vecs[i].fv, vecs[i].pc, vecs[i].i1, vecs[i].i2, vecs[i].t1, vecs[i].t2,
                  1'b0, vecs[i].dep, 1'b0, 32'h0);
            chk_issue($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ei, vecs[i].epc,
                      vecs[i].ov, vecs[i].oi, vecs[i].opc, vecs[i].rdy);
            tick();
            chk($sformatf("vec%0d pc_next", i), pc_next, vecs[i].pcn);
        end
        chk("table split_count", {16'h0, split_count}, 32'h2);

        // Stall 3 cycles in PAIR, then 2 in SECOND
        drive(1, 32'h18, 32'h6000_0007, 32'h6000_0008, 0, 1, 0, 0, 0, 0);
        chk_none("stl load", 1'b1);
        tick();
        chk("stl pc_next", pc_next, 32'h20);
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h20, 32'h1, 32'h2, 0, 1, 1, 0, 0, 0);
            chk_none($sformatf("stl pair%0d", i), 1'b0);
            tick();
        end
        drive(1, 32'h20, 32'h1, 32'h2, 0, 1, 0, 1, 0, 0);
        chk_issue("stl split1", 1'b1, 32'h6000_0007, 32'h18, 1'b0, c_LNOP, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 2; i++) begin
            drive(1, 32'h20, 32'h1, 32'h2, 0, 1, 1, 0, 0, 0);
            chk_none($sformatf("stl second%0d", i), 1'b0);
            tick();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        chk_issue("stl split2", 1'b0, c_NOP, 32'h0, 1'b1, 32'h6000_0008, 32'h1C, 1'b1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_none("stl after", 1'b1);
        tick();
        chk("stl stall_cycles", {16'h0, stall_cycles}, 32'h5);
        chk("stl split_count", {16'h0, split_count}, 32'h3);
        chk("stl pc_next hold", pc_next, 32'h20);

        // Flush while in SECOND with a fetch pair offered
        drive(1, 32'h20, 32'h7000_0009, 32'h7000_000A, 0, 0, 0, 0, 0, 0);
        chk_none("fl load", 1'b1);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_issue("fl split1", 1'b1, 32'h7000_0009, 32'h20, 1'b0, c_LNOP, 32'h0, 1'b0);
        tick();
        drive(1, 32'h28, 32'h5, 32'h6, 0, 1, 0, 0, 1, 32'h100);
        chk_none("fl flush", 1'b0);
        tick();
        chk("fl pc_next", pc_next, 32'h100);
        chk("fl flush_count", {16'h0, flush_count}, 32'h1);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_none("fl empty", 1'b1);
        tick();
        drive(1, 32'h100, 32'h8000_000B, 32'h8000_000C, 0, 1, 0, 0, 0, 0);
        chk_none("fl accept", 1'b1);
        tick();
        chk("fl pc_next+8", pc_next, 32'h108);

        // Random stimulus against a queue model of the buffered instructions
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        begin
            logic [31:0] m_pcn;
            logic [15:0] m_st, m_sp, m_fl;
            logic        fv, st, dp, fl, t1, t2, rdy, ev, ov;
            logic [31:0] i1, i2, tgt, ei, epc, oi, opc;
            m_pcn = 0; m_st = 0; m_sp = 0; m_fl = 0;
            mq.delete();
            for (int c = 0; c < 1500; c++) begin
                fv  = ($urandom_range(0, 9) < 7);
                st  = ($urandom_range(0, 9) < 2);
                dp  = ($urandom_range(0, 9) < 3);
                fl  = ($urandom_range(0, 9) == 0);
                t1  = 1'($urandom_range(0, 1));
                t2  = 1'($urandom_range(0, 1));
                i1  = $urandom;
                i2  = $urandom;
                tgt = $urandom & 32'hFFFF_FFFC;
                drive(fv, m_pcn, i1, i2, t1, t2, st, dp, fl, tgt);

                iss.delete();
                if (fl) begin
                    rdy = 0;
                    if (mq.size() != 0 && m_fl != 16'hFFFF) m_fl++;
                    mq.delete();
                end else if (mq.size() == 0) begin
                    rdy = 1;
                end else if (st) begin
                    rdy = 0;
                    if (m_st != 16'hFFFF) m_st++;
                end else if (mq.size() == 2 && (dp || mq[0].typ == mq[1].typ)) begin
                    rdy = 0;
                    iss.push_back(mq.pop_front());
                    if (m_sp != 16'hFFFF) m_sp++;
                end else begin
                    rdy = 1;
                    while (mq.size() != 0) iss.push_back(mq.pop_front());
                end
                ev = 0; ei = c_NOP; epc = 0; ov = 0; oi = c_LNOP; opc = 0;
                foreach (iss[k]) begin
                    if (iss[k].typ) begin ov = 1; oi = iss[k].instr; opc = iss[k].pc; end
                    else            begin ev = 1; ei = iss[k].instr; epc = iss[k].pc; end
                end
                chk_issue($sformatf("rnd%0d", c), ev, ei, epc, ov, oi, opc, rdy);

                if (fl) m_pcn = tgt;
                else if (fv && rdy) begin
                    mq.push_back('{i1, t1, m_pcn});
                    mq.push_back('{i2, t2, m_pcn + 32'd4});
                    m_pcn = m_pcn + 32'd8;
                end
                tick();
                chk($sformatf("rnd%0d pc_next", c), pc_next, m_pcn);
                chk($sformatf("rnd%0d counters", c), {stall_cycles, split_count},
                    {m_st, m_sp});
                chk($sformatf("rnd%0d flush_count", c), {16'h0, flush_count}, {16'h0, m_fl});
            end
        end

        // Saturate stall_cycles while holding in SECOND, then reset mid-split
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        drive(1, 32'h0, 32'h9000_000D, 32'h9000_000E, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk_issue("sat split1", 1'b1, 32'h9000_000D, 32'h0, 1'b0, c_LNOP, 32'h0, 1'b0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        repeat (65536 + 5) tick();
        chk_none("sat stalled", 1'b0);
        chk("sat stall_cycles", {16'h0, stall_cycles}, 32'hFFFF);
        chk("sat split_count", {16'h0, split_count}, 32'h1);
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        reset = 1'b0;
        chk_none("post reset", 1'b1);
        chk("post reset pc_next", pc_next, 32'h0);
        chk("post reset counters", {stall_cycles, split_count}, 32'h0);
        chk("post reset flush_count", {16'h0, flush_count}, 32'h0);
        tick();
        chk_none("post reset idle", 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
